fixdiv_seq: RTL and testbench
=============================

FIXDIV_SEQ -- requirements
Module: fixdiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits, two's complement, legal range 4..32.
REQ-002 SHALL have parameter FRAC, default 14: fraction bits of the Q(WIDTH-FRAC).FRAC format, legal range 0..WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-006 SHALL have port num, input, WIDTH bits: signed dividend, captured on acceptance.
REQ-007 SHALL have port den, input, WIDTH bits: signed divisor, captured on acceptance.
REQ-008 SHALL have port result, output, WIDTH bits: signed quotient, Q format as inputs.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-010 SHALL have port busy, output, 1 bit: high from acceptance until the cycle done is high, inclusive.
REQ-011 SHALL have port ovf, output, 1 bit: result saturated due to range overflow.
REQ-012 SHALL have port dz, output, 1 bit: divisor was zero.

Function
REQ-013 SHALL compute result = trunc_toward_zero((num * 2^FRAC) / den), saturated to the WIDTH-bit signed range.
REQ-014 SHALL use states IDLE, CALC, FIX, DONE; IDLE->CALC on start=1, CALC->FIX after N=WIDTH+FRAC iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-015 SHALL, on the acceptance edge, capture |num| and |den| as WIDTH+1-bit unsigned magnitudes (so -2^(WIDTH-1) is exact), the sign num[MSB]^den[MSB], and load the iteration counter with N.
REQ-016 SHALL, in CALC, perform one restoring shift-subtract step per cycle, producing one quotient bit per cycle, MSB first, over a dividend of |num| shifted left by FRAC bits.
REQ-017 SHALL, in FIX, negate the magnitude quotient when the sign is 1 and apply saturation/flags per REQ-018..020.
REQ-018 SHALL saturate a positive result whose magnitude exceeds 2^(WIDTH-1)-1 to 2^(WIDTH-1)-1 and set ovf=1.
REQ-019 SHALL saturate a negative result whose magnitude exceeds 2^(WIDTH-1) to -2^(WIDTH-1) and set ovf=1; magnitude exactly 2^(WIDTH-1) is exact with ovf=0.
REQ-020 SHALL, for den=0, set dz=1 and ovf=0, result = 2^(WIDTH-1)-1 if num>=0, else -2^(WIDTH-1); timing identical to a normal divide.
REQ-021 SHALL assert done for exactly one cycle in DONE, N+2 cycles after the acceptance edge (32 for defaults).
REQ-022 SHALL hold result, ovf and dz stable from DONE until the next acceptance edge, then update them only in FIX.
REQ-023 SHALL ignore start and num/den changes while busy=1; a start held high through DONE is accepted again in the following IDLE cycle.
REQ-024 SHALL not accept start in the same cycle done is high (minimum one IDLE cycle between operations).

Reset
REQ-025 SHALL, while reset=0, asynchronously force state=IDLE, result=0, done=0, busy=0, ovf=0, dz=0, and clear all internal registers.
REQ-026 SHALL abort any operation in progress on reset assertion with no done pulse; the first operation after reset release proceeds normally.

Verification
REQ-027 SHALL cover num=0x2000, den=0x4000 (0.5/1.0) -> result=0x2000, ovf=0, dz=0, done exactly 32 cycles after acceptance (defaults).
REQ-028 SHALL cover truncation: num=0x1000, den=0x3000 -> 0x1555; num=0xF000, den=0x3000 -> 0xEAAB (toward zero).
REQ-029 SHALL cover mixed signs: num=0x2000, den=0xC000 -> 0xE000; num=0xC000, den=0xC000 -> 0x4000.
REQ-030 SHALL cover overflow: num=0x4000, den=0x2000 -> 0x7FFF, ovf=1; num=0xC000, den=0x2000 -> 0x8000, ovf=0; num=0x8000, den=0x4000 -> 0x8000, ovf=0.
REQ-031 SHALL cover divide by zero: num=0x1000, den=0 -> 0x7FFF, dz=1; num=0xF000, den=0 -> 0x8000, dz=1.
REQ-032 SHALL cover reset=0 at cycle 10 of CALC -> outputs zero immediately, no done; next start after release yields the correct result; also start pulsed mid-CALC -> ignored.

Source files
------------

// File: rtl/fixdiv_seq.sv
// Sequential signed fixed-point divider: Q(WIDTH-FRAC).FRAC quotient computed by
// restoring shift-subtract, one quotient bit per clock, then sign fix and saturation.
module fixdiv_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             ovf,
  output logic             dz
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  // Largest positive result, and the largest magnitude a negative result can carry.
  localparam logic [N-1:0] POS_MAX = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0] NEG_MAG = POS_MAX + N'(1);
  localparam logic [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_N   = CW'(N);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   dq;      // dividend shifting out the top, quotient shifting in below
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0] dmag;
  logic           sign;
  logic           zero_den;

  // Magnitudes are WIDTH+1 bits so the most negative operand stays exact.
  logic [WIDTH:0] num_x, den_x, num_mag, den_mag;
  logic [WIDTH:0] trial;
  logic           qbit;

  assign num_x   = {num[WIDTH-1], num};
  assign den_x   = {den[WIDTH-1], den};
  assign num_mag = num[WIDTH-1] ? -num_x : num_x;
  assign den_mag = den[WIDTH-1] ? -den_x : den_x;

  assign trial = {rem, dq[N-1]};
  assign qbit  = (trial >= dmag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done = (state == DONE);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      dq       <= '0;
      rem      <= '0;
      dmag     <= '0;
      sign     <= 1'b0;
      zero_den <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt      <= CNT_N;
          dq       <= N'(num_mag[WIDTH-1:0]) << FRAC;
          rem      <= '0;
          dmag     <= den_mag;
          sign     <= num[WIDTH-1] ^ den[WIDTH-1];
          zero_den <= (den == '0);
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          rem <= qbit ? WIDTH'(trial - dmag) : trial[WIDTH-1:0];
          dq  <= {dq[N-2:0], qbit};
        end
        FIX: begin
          if (zero_den) begin
            // With a zero divisor the sign is that of the dividend alone.
            result <= sign ? RES_MIN : RES_MAX;
            ovf    <= 1'b0;
            dz     <= 1'b1;
          end else if (!sign) begin
            result <= (dq > POS_MAX) ? RES_MAX : dq[WIDTH-1:0];
            ovf    <= (dq > POS_MAX);
            dz     <= 1'b0;
          end else begin
            result <= (dq > NEG_MAG) ? RES_MIN : -dq[WIDTH-1:0];
            ovf    <= (dq > NEG_MAG);
            dz     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixdiv_seq.sv
// Directed bench for fixdiv_seq at default parameters (Q2.14).
module tb_fixdiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num, den;
  logic [15:0] result;
  logic        done, busy, ovf, dz;

  int n_checks = 0;
  int n_fails  = 0;

  fixdiv_seq #(.WIDTH(16), .FRAC(14)) dut (
    .clk(clk), .reset(reset), .start(start), .num(num), .den(den),
    .result(result), .done(done), .busy(busy), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one divide; optionally pulse start with junk operands at CALC cycle mid.
  task automatic run(input logic [15:0] n, input logic [15:0] d, input logic [15:0] er,
                     input logic eo, input logic ez, input string tag, input int mid);
    int  cyc;
    logic got;
    @(negedge clk);
    num = n; den = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    num = 16'h7ABC; den = 16'h0001;
    cyc = 0; got = 1'b0;
    while (cyc < 100 && !got) begin
      @(negedge clk);
      cyc++;
      got = done;
      start = (mid > 0 && cyc == mid);
    end
    start = 1'b0;
    chk(cyc, 32, {tag, " latency"});
    chk(result, er, {tag, " result"});
    chk(ovf, eo, {tag, " ovf"});
    chk(dz, ez, {tag, " dz"});
    chk(busy, 1, {tag, " busy at done"});
    @(negedge clk);
    chk({done, busy}, 2'b00, {tag, " idle after done"});
    chk(result, er, {tag, " result held"});
  endtask

  initial begin
    int cyc;
    logic seen;
    reset = 1'b0; start = 1'b0; num = '0; den = '0;
    repeat (3) @(negedge clk);
    chk({result, done, busy, ovf, dz}, 20'h0, "reset state");
    reset = 1'b1;
    @(negedge clk);
    chk({done, busy}, 2'b00, "idle after release");

    run(16'h2000, 16'h4000, 16'h2000, 1'b0, 1'b0, "half/one", 0);
    run(16'h1000, 16'h3000, 16'h1555, 1'b0, 1'b0, "trunc pos", 0);
    run(16'hF000, 16'h3000, 16'hEAAB, 1'b0, 1'b0, "trunc neg", 0);
    run(16'h2000, 16'hC000, 16'hE000, 1'b0, 1'b0, "mixed sign", 0);
    run(16'hC000, 16'hC000, 16'h4000, 1'b0, 1'b0, "both neg", 0);
    run(16'h4000, 16'h2000, 16'h7FFF, 1'b1, 1'b0, "ovf pos", 0);
    run(16'hC000, 16'h2000, 16'h8000, 1'b0, 1'b0, "exact min", 0);
    run(16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b0, "min operand", 0);
    run(16'h8000, 16'h2000, 16'h8000, 1'b1, 1'b0, "ovf neg", 0);
    run(16'h1000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, "dz pos", 0);
    run(16'hF000, 16'h0000, 16'h8000, 1'b0, 1'b1, "dz neg", 0);
    run(16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, "dz zero num", 0);
    run(16'h1000, 16'h3000, 16'h1555, 1'b0, 1'b0, "mid start ignored", 5);

    // Reset during CALC: outputs clear at once and no done follows.
    @(negedge clk);
    num = 16'h2000; den = 16'hC000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk({result, done, busy, ovf, dz}, 20'h0, "async reset mid calc");
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk(seen, 0, "no done after abort");
    run(16'hC000, 16'hC000, 16'h4000, 1'b0, 1'b0, "after reset", 0);

    // Start held high through DONE is re-accepted after one IDLE cycle.
    @(negedge clk);
    num = 16'h2000; den = 16'h4000; start = 1'b1;
    cyc = 0; seen = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      seen = done;
    end
    chk(seen, 1, "held start first done");
    num = 16'hF000; den = 16'h3000;
    @(negedge clk);
    chk(busy, 0, "held start idle gap");
    @(negedge clk);
    chk(busy, 1, "held start reaccepted");
    start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      seen = done;
    end
    chk(cyc, 31, "held start second latency");
    chk(result, 16'hEAAB, "held start second result");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
